// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: controller states and the
// default iteration count (one quotient bit per CALC cycle).
package div_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } div_state_e;

   localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_negate.sv
// Conditional two's-complement negate; passes the value through when neg=0.
module div_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             neg,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = neg ? (~value + WIDTH'(1)) : value;
   end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider, signed/unsigned, one quotient bit per cycle.
// Results are registered in FIXUP and held until the next FIXUP.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_ITERS,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   div_state_e       state_q, state_d;
   logic             sign_q;
   logic             dz_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] dvs_mag_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] rem_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH-1:0] q_fix, r_fix;
   logic             q_neg, r_neg;
   logic [WIDTH:0]   partial, diff;
   logic             ge;
   logic             last_iter;

   div_negate #(.WIDTH(WIDTH)) u_neg_dvd (
      .value (dividend),
      .neg   (sign & dividend[WIDTH-1]),
      .result(dvd_mag)
   );

   div_negate #(.WIDTH(WIDTH)) u_neg_dvs (
      .value (divisor),
      .neg   (sign & divisor[WIDTH-1]),
      .result(dvs_mag)
   );

   assign q_neg = sign_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
   assign r_neg = sign_q & dvd_q[WIDTH-1];

   div_negate #(.WIDTH(WIDTH)) u_neg_quo (
      .value (acc_q),
      .neg   (q_neg),
      .result(q_fix)
   );

   div_negate #(.WIDTH(WIDTH)) u_neg_rem (
      .value (rem_q),
      .neg   (r_neg),
      .result(r_fix)
   );

   // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
   always_comb begin
      partial   = {rem_q, acc_q[WIDTH-1]};
      diff      = partial - {1'b0, dvs_mag_q};
      ge        = (partial >= {1'b0, dvs_mag_q});
      last_iter = (cnt_q == CNT_W'(WIDTH-1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (last_iter) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q    <= 1'b0;
         dz_q      <= 1'b0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         dvs_mag_q <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (!flush) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sign_q    <= sign;
                  dz_q      <= (divisor == '0);
                  dvd_q     <= dividend;
                  dvs_q     <= divisor;
                  dvs_mag_q <= dvs_mag;
                  acc_q     <= dvd_mag;
                  rem_q     <= '0;
                  cnt_q     <= '0;
               end
            end
            S_CALC: begin
               acc_q <= {acc_q[WIDTH-2:0], ge};
               rem_q <= ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
               cnt_q <= cnt_q + CNT_W'(1);
            end
            S_FIXUP: begin
               // Divide-by-zero bypasses the sign fixup entirely.
               quotient  <= dz_q ? '1 : q_fix;
               remainder <= dz_q ? dvd_q : r_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter CNT_W, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-006 SHALL have port sign, input, 1: 1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
REQ-007 SHALL have port dividend, input, WIDTH: numerator; captured with start.
REQ-008 SHALL have port divisor, input, WIDTH: denominator; captured with start.
REQ-009 SHALL have port flush, input, 1: abort any operation in progress.
REQ-010 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-011 SHALL have port done, output, 1: single-cycle pulse; results are valid in that cycle.
REQ-012 SHALL have port quotient, output, WIDTH: registered LO result.
REQ-013 SHALL have port remainder, output, WIDTH: registered HI result.

Function
REQ-014 SHALL implement four states: IDLE, CALC, FIXUP, DONE.
REQ-015 SHALL move IDLE->CALC on an edge where start=1 and flush=0, latching sign, dividend, divisor, the operand magnitudes (two's-complement absolute values when sign=1) and a divide-by-zero flag; the counter clears to 0.
REQ-016 SHALL perform radix-2 restoring division in CALC, one quotient bit per cycle, MSB first, for exactly WIDTH cycles; then CALC->FIXUP.
REQ-017 In FIXUP: SHALL negate the quotient when sign=1 and the operand signs differ, SHALL give the remainder the sign of the dividend when sign=1, SHALL load both results into the output registers, then FIXUP->DONE.
REQ-018 In DONE: SHALL assert done=1 for one cycle, then DONE->IDLE unconditionally.
REQ-019 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E0+WIDTH+1 (cycle 34 for WIDTH=32); back-to-back throughput is one result per WIDTH+3 cycles.
REQ-020 start while busy=1, including in the DONE cycle, SHALL be ignored with no queuing.
REQ-021 Divisor zero in either mode: quotient SHALL be all ones and remainder SHALL equal the raw dividend, with normal latency.
REQ-022 Signed overflow (most negative value / -1): quotient SHALL be the most negative value and remainder SHALL be 0.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge with no done pulse; quotient and remainder SHALL keep their previous values.
REQ-024 flush and start high in the same IDLE cycle: flush SHALL win and no operation is accepted.
REQ-025 quotient and remainder SHALL hold their values from the last DONE until the next FIXUP.
REQ-026 All internal arithmetic SHALL be WIDTH+1 bits wide so the restoring subtract never loses the borrow.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and set busy=0, done=0, quotient=0, remainder=0 and counter=0, overriding start and flush.
REQ-028 rst asserted mid-CALC SHALL abandon the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-029 The state encoding (IDLE, CALC, FIXUP, DONE) and the iteration-count constant SHALL live in the shared CPU package; no other typedefs are needed.
REQ-030 SHALL instantiate one sub-module, div_negate: a combinational conditional two's-complement negate of WIDTH bits, used for both the operand magnitudes and the result fixup.
REQ-031 SHALL be fully synchronous, with no latches and no combinational path from any input to done or busy.

Verification
REQ-032 Unsigned: dividend=100, divisor=7, sign=0 -> done in cycle 34, quotient=14, remainder=2.
REQ-033 Signed: dividend=0xFFFFFFF9 (-7), divisor=2, sign=1 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-034 Overflow: dividend=0x80000000, divisor=0xFFFFFFFF, sign=1 -> quotient=0x80000000, remainder=0.
REQ-035 Divide by zero: dividend=0x12345678, divisor=0, sign=1 -> quotient=0xFFFFFFFF, remainder=0x12345678, done in cycle 34.
REQ-036 Flush: start 50/5, flush in cycle 10 -> busy=0 in cycle 11, no done, outputs unchanged; then start 9/3 -> quotient=3, remainder=0.
REQ-037 Busy and reset: start pulsed in cycle 5 during an operation -> ignored, exactly one done; rst in cycle 20 of a second operation -> all outputs 0, no done.
